pipeline_issue_ctrl: RTL and testbench
======================================

# pipeline_issue_ctrl

Issue controller between the stage-0 instruction decoder and the execute stage. It takes decoded control fields, detects read-after-write hazards against in-flight register writes using a per-register countdown scoreboard, and stalls decode until each source operand is safe. Accepted instructions go into a one-entry output register with a valid/ready handshake. Optional operand forwarding removes most ALU-to-ALU stalls.

## Interface
- WB_LAT, 3: advancing cycles from issue until an ALU result is readable from the register file; must be ≥3.
- LD_EXTRA, 1: extra cycles added to WB_LAT for LDR; WB_LAT+LD_EXTRA must be ≤7.

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- dec_valid  in  1  decoder presents an instruction
- dec_ready  out  1  instruction accepted this cycle; combinational
- dec_opcode  in  3  opcode field of control_out
- dec_num_Rm, dec_num_Rn, dec_num_Rd  in  3 each  source register numbers
- dec_used  in  3  {Rm,Rn,Rd} source-used flags
- dec_write  in  1  instruction writes a register
- dec_writenum  in  3  destination register
- flush  in  1  kill the output register and block acceptance this cycle
- iss_ready  in  1  execute stage accepts or advances
- iss_valid  out  1  output register holds an instruction
- iss_opcode  out  3  registered opcode of the issued instruction
- fwd_sel_Rm, fwd_sel_Rn, fwd_sel_Rd  out  2 each  operand source, registered with the issue
- busy_mask  out  8  bit r is set while cnt[r]≠0
- stall_cnt  out  16  saturating count of hazard stall cycles

## Operation
- Scoreboard: cnt[r] is 3 bits per register, and ld[r] marks that the pending write is an LDR. When iss_ready=1, every nonzero cnt decrements by 1.
- fire = dec_valid & dec_ready.
- On fire with dec_write=1 and dec_opcode≠000:
  - cnt[writenum] loads WB_LAT, or WB_LAT+LD_EXTRA for opcode 011 (LDR).
  - ld[writenum] is set for LDR and cleared otherwise.
  - The load has priority over a decrement of the same register.
- Hazard on source s (dec_used bit set) when cnt[num_s]≠0 and s cannot be forwarded.
  - Register 0 is not special.
  - Opcode 000 (NOP) never hazards and never loads the scoreboard.
- dec_ready = ~hazard & ~flush & (~iss_valid | iss_ready).
- Output register: on fire, iss_valid←1 and iss_opcode/fwd_sel←new values. Otherwise, when iss_ready=1, iss_valid←0.
- Flush: iss_valid←0 on the next edge. Scoreboard is untouched because older instructions still write back. Flush has priority over fire.
- stall_cnt increments on every cycle with dec_valid & hazard & ~flush, and saturates at 0xFFFF.
- A source with cnt=0 is never a hazard. Reset mid-stall drops the pending instruction's acceptance.
- Reset values:
  - cnt and ld all 0
  - iss_valid 0, iss_opcode 000
  - fwd_sel all 00, busy_mask 00, stall_cnt 0

## Timing
- dec_ready depends combinationally on dec_* inputs, flush and iss_ready; it is not registered.
- Issue latency is 1 cycle: a fire at edge t gives iss_valid=1 after t.
- Without forwarding, back-to-back dependents stall WB_LAT cycles, or WB_LAT+LD_EXTRA cycles behind an LDR.
- A downstream stall (iss_ready=0) freezes all counters, so stall length is measured in advancing cycles.

## Configuration
- HAZARD_FWD_EN defined: a source with nonzero cnt is forwarded instead of stalling when:
  - cnt=WB_LAT and ld=0 → select 01 (execute result)
  - cnt=WB_LAT-1 and ld=0 → select 10 (memory-stage result)
  - cnt=1, any ld → select 11 (writeback value)
  - Any other nonzero cnt is a hazard. fwd_sel=00 selects the register file.
- Not defined: every nonzero cnt is a hazard. fwd_sel outputs stay 00 and ld is still maintained.

## Test plan
All cases use WB_LAT=3, LD_EXTRA=1 and iss_ready=1 unless stated.
- MOV R1,#5, then ADD R2,R1,R0 (used=110), macro off → ADD stalls 3 cycles and fires on cycle 4; stall_cnt=3; busy_mask=0x02 for 3 cycles.
- Same sequence, macro on → no stall; ADD issues with fwd_sel_Rm=01.
- LDR R3,[R1,#2], then STR R3,[R4] (Rd=R3 used) → 4 stalls with the macro off. With it on, 3 stalls, then fwd_sel_Rd=11.
- Hazarded dependent with iss_ready held 0 for 5 cycles → cnt stays frozen and stall_cnt grows by 5. After release, the remaining stalls are unchanged.
- Issue, then flush asserted together with dec_valid → iss_valid=0 next cycle, no fire, busy_mask keeps the earlier write.
- Reset asserted mid-stall (async) → all outputs reach their reset values immediately; the stalled instruction fires on the first cycle after reset release.

Source files
------------

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller: per-register countdown scoreboard, RAW stall logic and a one-entry issue register.
// Define HAZARD_FWD_EN to forward in-flight results instead of stalling on them.
module pipeline_issue_ctrl #(
    parameter int WB_LAT   = 3,
    parameter int LD_EXTRA = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [2:0]  dec_opcode,
    input  logic [2:0]  dec_num_Rm,
    input  logic [2:0]  dec_num_Rn,
    input  logic [2:0]  dec_num_Rd,
    input  logic [2:0]  dec_used,
    input  logic        dec_write,
    input  logic [2:0]  dec_writenum,
    input  logic        flush,
    input  logic        iss_ready,
    output logic        iss_valid,
    output logic [2:0]  iss_opcode,
    output logic [1:0]  fwd_sel_Rm,
    output logic [1:0]  fwd_sel_Rn,
    output logic [1:0]  fwd_sel_Rd,
    output logic [7:0]  busy_mask,
    output logic [15:0] stall_cnt
);
`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] LAT_ALU = 3'(WB_LAT);
    localparam logic [2:0] LAT_MEM = 3'(WB_LAT - 1);
    localparam logic [2:0] LAT_LDR = 3'(WB_LAT + LD_EXTRA);

    logic [7:0][2:0] cnt_all;
    logic [7:0]      ld_all;
    logic [2:0][2:0] src_num;
    logic [2:0][1:0] src_fwd;
    logic [2:0]      src_haz;
    logic            hazard;
    logic            fire;
    logic            sb_load;
    logic            load_is_ldr;

    logic            iss_valid_reg;
    logic [2:0]      iss_opcode_reg;
    logic [2:0][1:0] fwd_sel_reg;
    logic [15:0]     stall_cnt_reg;

    // Source slots are ordered to match dec_used: [2]=Rm, [1]=Rn, [0]=Rd.
    assign src_num = {dec_num_Rm, dec_num_Rn, dec_num_Rd};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            logic [2:0] src_cnt;
            logic       src_ld;
            logic       src_chk;
            logic [1:0] fwd_raw;

            assign src_cnt = cnt_all[src_num[gi]];
            assign src_ld  = ld_all[src_num[gi]];
            assign src_chk = dec_used[gi] && (dec_opcode != OP_NOP);

            // A load result only exists at writeback, so ld blocks the early taps.
            assign fwd_raw = (src_cnt == LAT_ALU && !src_ld) ? 2'b01 :
                             (src_cnt == LAT_MEM && !src_ld) ? 2'b10 :
                             (src_cnt == 3'd1)               ? 2'b11 : 2'b00;

            assign src_fwd[gi] = (FWD_EN && src_chk) ? fwd_raw : 2'b00;
            assign src_haz[gi] = src_chk && (src_cnt != 3'd0) && (src_fwd[gi] == 2'b00);
        end
    endgenerate

    assign hazard      = |src_haz;
    assign dec_ready   = !hazard && !flush && (!iss_valid_reg || iss_ready);
    assign fire        = dec_valid && dec_ready;
    assign sb_load     = fire && dec_write && (dec_opcode != OP_NOP);
    assign load_is_ldr = (dec_opcode == OP_LDR);

    generate
        for (gi = 0; gi < 8; gi++) begin : g_sb
            logic [2:0] cnt_reg;
            logic       ld_reg;
            logic       load_here;

            assign load_here = sb_load && (dec_writenum == 3'(gi));

            // A new write to the register overrides the countdown of the older one.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= 3'd0;
                    ld_reg  <= 1'b0;
                end else if (load_here) begin
                    cnt_reg <= load_is_ldr ? LAT_LDR : LAT_ALU;
                    ld_reg  <= load_is_ldr;
                end else if (iss_ready && cnt_reg != 3'd0) begin
                    cnt_reg <= cnt_reg - 3'd1;
                end
            end

            assign cnt_all[gi]   = cnt_reg;
            assign ld_all[gi]    = ld_reg;
            assign busy_mask[gi] = (cnt_reg != 3'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_reg  <= 1'b0;
            iss_opcode_reg <= 3'b000;
            fwd_sel_reg    <= '0;
            stall_cnt_reg  <= 16'd0;
        end else begin
            // flush already blocks fire through dec_ready, so it only needs to kill the entry.
            if (fire) begin
                iss_valid_reg  <= 1'b1;
                iss_opcode_reg <= dec_opcode;
                fwd_sel_reg    <= src_fwd;
            end else if (flush || iss_ready) begin
                iss_valid_reg <= 1'b0;
            end

            if (dec_valid && hazard && !flush && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign iss_valid  = iss_valid_reg;
    assign iss_opcode = iss_opcode_reg;
    assign fwd_sel_Rm = fwd_sel_reg[2];
    assign fwd_sel_Rn = fwd_sel_reg[1];
    assign fwd_sel_Rd = fwd_sel_reg[0];
    assign stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench for pipeline_issue_ctrl: directed hazard scenarios plus random traffic
// compared every cycle against a due-time model of register readiness.
module tb_pipeline_issue_ctrl;
    localparam int WB = 3;
    localparam int LX = 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic        dec_ready;
    logic [2:0]  dec_opcode;
    logic [2:0]  dec_num_Rm, dec_num_Rn, dec_num_Rd;
    logic [2:0]  dec_used;
    logic        dec_write;
    logic [2:0]  dec_writenum;
    logic        flush;
    logic        iss_ready;
    logic        iss_valid;
    logic [2:0]  iss_opcode;
    logic [1:0]  fwd_sel_Rm, fwd_sel_Rn, fwd_sel_Rd;
    logic [7:0]  busy_mask;
    logic [15:0] stall_cnt;

    pipeline_issue_ctrl #(.WB_LAT(WB), .LD_EXTRA(LX)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
        .dec_num_Rm(dec_num_Rm), .dec_num_Rn(dec_num_Rn), .dec_num_Rd(dec_num_Rd),
        .dec_used(dec_used), .dec_write(dec_write), .dec_writenum(dec_writenum),
        .flush(flush), .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
        .fwd_sel_Rm(fwd_sel_Rm), .fwd_sel_Rn(fwd_sel_Rn), .fwd_sel_Rd(fwd_sel_Rd),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a register is readable once the count of advancing cycles reaches due[r].
    int         adv;
    int         due [8];
    bit         ldm [8];
    bit         m_valid;
    logic [2:0] m_op;
    logic [1:0] m_sel [3];
    int         m_stall;
    bit         chk_en;

    bit         c_haz, c_ready, c_fire;
    logic [1:0] c_sel [3];
    logic [2:0] c_num;
    int         c_busy;

    function automatic int remaining(input int r);
        int d;
        d = due[r] - adv;
        return (d > 0) ? d : 0;
    endfunction

    function automatic logic [1:0] fwd_of(input int r);
        int d;
        d = remaining(r);
        if (!FWD || d == 0) return 2'b00;
        if (d == WB && !ldm[r]) return 2'b01;
        if (d == WB - 1 && !ldm[r]) return 2'b10;
        if (d == 1) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_init();
        adv = 0;
        for (int r = 0; r < 8; r++) begin
            due[r] = 0;
            ldm[r] = 1'b0;
        end
        m_valid = 1'b0;
        m_op    = 3'b000;
        for (int s = 0; s < 3; s++) m_sel[s] = 2'b00;
        m_stall = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            c_haz = 1'b0;
            for (int s = 0; s < 3; s++) begin
                c_num    = (s == 0) ? dec_num_Rd : (s == 1) ? dec_num_Rn : dec_num_Rm;
                c_sel[s] = 2'b00;
                if (dec_used[s] && dec_opcode != 3'b000) begin
                    c_sel[s] = fwd_of(int'(c_num));
                    if (remaining(int'(c_num)) > 0 && c_sel[s] == 2'b00) c_haz = 1'b1;
                end
            end
            c_ready = !c_haz && !flush && (!m_valid || iss_ready);
            c_busy  = 0;
            for (int r = 0; r < 8; r++) if (remaining(r) > 0) c_busy += (1 << r);

            check("dec_ready", int'(dec_ready), int'(c_ready));
            check("iss_valid", int'(iss_valid), int'(m_valid));
            check("iss_opcode", int'(iss_opcode), int'(m_op));
            check("fwd_sel_Rm", int'(fwd_sel_Rm), int'(m_sel[2]));
            check("fwd_sel_Rn", int'(fwd_sel_Rn), int'(m_sel[1]));
            check("fwd_sel_Rd", int'(fwd_sel_Rd), int'(m_sel[0]));
            check("busy_mask", int'(busy_mask), c_busy);
            check("stall_cnt", int'(stall_cnt), m_stall);

            c_fire = dec_valid && c_ready;
            if (dec_valid && c_haz && !flush && m_stall < 65535) m_stall++;
            if (iss_ready) adv++;
            if (c_fire && dec_write && dec_opcode != 3'b000) begin
                due[dec_writenum] = adv + ((dec_opcode == 3'b011) ? WB + LX : WB);
                ldm[dec_writenum] = (dec_opcode == 3'b011);
            end
            if (c_fire) begin
                m_valid = 1'b1;
                m_op    = dec_opcode;
                for (int s = 0; s < 3; s++) m_sel[s] = c_sel[s];
                $display("issue t=%0t op=%0d Rm=%0d Rn=%0d Rd=%0d used=%b wr=%0d->R%0d sel=%0d/%0d/%0d",
                         $time, dec_opcode, dec_num_Rm, dec_num_Rn, dec_num_Rd, dec_used,
                         dec_write, dec_writenum, c_sel[2], c_sel[1], c_sel[0]);
            end else if (flush || iss_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [2:0] rm, input logic [2:0] rn,
                             input logic [2:0] rd, input logic [2:0] used, input logic wr,
                             input logic [2:0] wn);
        dec_valid    = 1'b1;
        dec_opcode   = op;
        dec_num_Rm   = rm;
        dec_num_Rn   = rn;
        dec_num_Rd   = rd;
        dec_used     = used;
        dec_write    = wr;
        dec_writenum = wn;
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        flush     = 1'b0;
        iss_ready = 1'b1;
        repeat (n) tick();
    endtask

    // Counts cycles with dec_ready low, bounded so a stuck design still reaches the summary.
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (!dec_ready && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    int n_st, s0;

    initial begin
        chk_en = 1'b0;
        reset  = 1'b1;
        set_instr(3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0);
        dec_valid = 1'b0;
        flush     = 1'b0;
        iss_ready = 1'b1;
        model_init();
        tick();
        check("reset_iss_valid", int'(iss_valid), 0);
        check("reset_busy_mask", int'(busy_mask), 0);
        check("reset_stall_cnt", int'(stall_cnt), 0);
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // MOV R1 then dependent ADD R2,R1,R0.
        set_instr(3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd1);
        #1 check("mov_ready", int'(dec_ready), 1);
        tick();
        set_instr(3'b010, 3'd1, 3'd0, 3'd2, 3'b110, 1'b1, 3'd2);
        s0 = int'(stall_cnt);
        #1 check("add_busy_mask", int'(busy_mask), 8'h02);
        count_stalls(n_st);
        check("add_stalls", n_st, FWD ? 0 : 3);
        tick();
        check("add_iss_valid", int'(iss_valid), 1);
        check("add_fwd_Rm", int'(fwd_sel_Rm), FWD ? 1 : 0);
        check("add_stall_cnt", int'(stall_cnt) - s0, FWD ? 0 : 3);
        idle(8);

        // LDR R3 then STR R3,[R4].
        set_instr(3'b011, 3'd1, 3'd0, 3'd3, 3'b100, 1'b1, 3'd3);
        #1 check("ldr_ready", int'(dec_ready), 1);
        tick();
        set_instr(3'b100, 3'd0, 3'd4, 3'd3, 3'b011, 1'b0, 3'd0);
        count_stalls(n_st);
        check("str_stalls", n_st, FWD ? 3 : 4);
        tick();
        check("str_opcode", int'(iss_opcode), 4);
        check("str_fwd_Rd", int'(fwd_sel_Rd), FWD ? 3 : 0);
        idle(8);

        // Same dependency with a 5-cycle downstream freeze after the first stall.
        set_instr(3'b011, 3'd1, 3'd0, 3'd3, 3'b100, 1'b1, 3'd3);
        tick();
        set_instr(3'b100, 3'd0, 3'd4, 3'd3, 3'b011, 1'b0, 3'd0);
        #1 check("frz_first_stall", int'(dec_ready), 0);
        tick();
        iss_ready = 1'b0;
        s0 = int'(stall_cnt);
        repeat (5) tick();
        check("frz_stall_growth", int'(stall_cnt) - s0, 5);
        check("frz_busy_mask", int'(busy_mask), 8'h08);
        iss_ready = 1'b1;
        count_stalls(n_st);
        check("frz_remaining", n_st, FWD ? 2 : 3);
        tick();
        check("frz_iss_valid", int'(iss_valid), 1);
        idle(8);

        // Flush alongside a valid instruction while the issue register is held.
        set_instr(3'b001, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd6);
        tick();
        iss_ready = 1'b0;
        flush     = 1'b1;
        set_instr(3'b010, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd5);
        #1 check("flush_ready", int'(dec_ready), 0);
        tick();
        check("flush_iss_valid", int'(iss_valid), 0);
        check("flush_busy_mask", int'(busy_mask), 8'h40);
        idle(8);

        // Asynchronous reset in the middle of an LDR-dependent stall.
        set_instr(3'b011, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd5);
        tick();
        set_instr(3'b010, 3'd5, 3'd0, 3'd2, 3'b100, 1'b1, 3'd2);
        tick();
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("arst_iss_valid", int'(iss_valid), 0);
        check("arst_iss_opcode", int'(iss_opcode), 0);
        check("arst_busy_mask", int'(busy_mask), 0);
        check("arst_stall_cnt", int'(stall_cnt), 0);
        check("arst_fwd_Rm", int'(fwd_sel_Rm), 0);
        check("arst_dec_ready", int'(dec_ready), 1);
        tick();
        reset = 1'b0;
        model_init();
        chk_en = 1'b1;
        tick();
        check("post_rst_fire", int'(iss_valid), 1);
        check("post_rst_opcode", int'(iss_opcode), 2);
        idle(8);

        // Random traffic checked cycle by cycle by the model.
        for (int i = 0; i < 1500; i++) begin
            dec_valid    = ($urandom_range(0, 9) < 7);
            dec_opcode   = 3'($urandom_range(0, 7));
            dec_num_Rm   = 3'($urandom_range(0, 3));
            dec_num_Rn   = 3'($urandom_range(0, 3));
            dec_num_Rd   = 3'($urandom_range(0, 3));
            dec_used     = 3'($urandom_range(0, 7));
            dec_write    = ($urandom_range(0, 3) != 0);
            dec_writenum = 3'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 15) == 0);
            iss_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle(8);

        // Saturation: a hazard held against a frozen pipeline.
        set_instr(3'b011, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd7);
        tick();
        set_instr(3'b010, 3'd7, 3'd0, 3'd1, 3'b100, 1'b1, 3'd1);
        iss_ready = 1'b0;
        repeat (65540) tick();
        check("stall_cnt_saturated", int'(stall_cnt), 65535);
        idle(4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
